// File: rtl/classificador_pkg.sv
// Shared definitions for the N-channel level classifier: class codes, FSM
// state encoding and small arithmetic helpers.
package classificador_pkg;

  localparam logic [2:0] DESCONHECIDO = 3'd0;
  localparam logic [2:0] BAIXO        = 3'd1;
  localparam logic [2:0] NORMAL       = 3'd2;
  localparam logic [2:0] ALTO         = 3'd3;
  localparam logic [2:0] CRITICO      = 3'd4;

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    CAPTURA    = 4'd1,
    ACUMULA    = 4'd2,
    VERIFICA   = 4'd3,
    DIVIDE     = 4'd4,
    CLASSIFICA = 4'd5,
    FIM        = 4'd6
  } estado_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Threshold +/- margin, clamped to [0, maximo].
  function automatic logic [31:0] ajusta_limiar(input logic [31:0] t,
                                                input logic [31:0] h,
                                                input logic        soma,
                                                input logic [31:0] maximo);
    logic [32:0] s;
    if (soma) begin
      s = {1'b0, t} + {1'b0, h};
      return (s > {1'b0, maximo}) ? maximo : s[31:0];
    end
    return (t < h) ? 32'd0 : (t - h);
  endfunction

endpackage

// File: rtl/classificador_nivel_n_divisor_seq.sv
// Restoring divider by a constant: one quotient bit per cycle, DW cycles
// from start to the pronto pulse.
module divisor_seq
  import classificador_pkg::*;
#(
  parameter int DW      = 14,
  parameter int DIVISOR = 3,
  parameter int QW      = DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          start,
  input  logic [DW-1:0] dividendo,
  output logic          pronto,
  output logic [QW-1:0] quociente
);

  localparam int KW = (clog2(DIVISOR) < 1) ? 1 : clog2(DIVISOR);
  localparam int CW = clog2(DW + 1);

  logic [KW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [KW:0]   tentativa;
  logic          cabe;

  always_comb begin
    tentativa = {rem_q, quo_q[DW-1]};
    cabe      = (tentativa >= (KW+1)'(DIVISOR));
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (clear) begin
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividendo;
      cnt_d  = CW'(DW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // remainder stays below DIVISOR, so the narrowing is lossless
      rem_d  = cabe ? KW'(tentativa - (KW+1)'(DIVISOR)) : KW'(tentativa);
      quo_d  = {quo_q[DW-2:0], cabe};
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign pronto    = busy_q && (cnt_q == CW'(1));
  assign quociente = quo_q[QW-1:0];

endmodule

// File: rtl/classificador_nivel_n.sv
// N-channel level classifier: capture, validate spread, exact floor mean,
// then banded classification with hysteresis and multi-round confirmation.
//   state      | meaning
//   OCIOSO     | idle, waits for iniciar
//   CAPTURA    | latch medidas, clear accumulators
//   ACUMULA    | fold one channel per cycle into sum/min/max/zero
//   VERIFICA   | reject on zero channel or excessive spread
//   DIVIDE     | sequential sum/N
//   CLASSIFICA | band, hysteresis, confirmation
//   FIM        | round done; completion pulse follows
module classificador_nivel_n
  import classificador_pkg::*;
#(
  parameter int N          = 3,
  parameter int W          = 12,
  parameter int MAX_SPREAD = 20,
  parameter int HYST       = 2,
  parameter int CONFIRMA   = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           zera,
  input  logic           iniciar,
  input  logic [N*W-1:0] medidas,
  input  logic [W-1:0]   nv_crit,
  input  logic [W-1:0]   nv_alto,
  input  logic [W-1:0]   nv_baixo,
  output logic [W-1:0]   media,
  output logic [2:0]     classificacao,
  output logic           descartar_medida,
  output logic           fim_classificacao,
  output logic           ocupado,
  output logic [3:0]     db_estado
);

  localparam int          SW    = W + clog2(N);
  localparam logic [31:0] T_MAX = 32'({W{1'b1}});

  estado_t        estado_q, estado_d;
  logic [N*W-1:0] med_q, med_d;
  logic [3:0]     idx_q, idx_d;
  logic [SW-1:0]  soma_q, soma_d;
  logic [W-1:0]   min_q, min_d, max_q, max_d;
  logic           zero_q, zero_d, disc_q, disc_d;
  logic [W-1:0]   media_q, media_d;
  logic [2:0]     classe_q, classe_d, cand_q, cand_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           fim_q, fim_d, descartar_q, descartar_d;

  logic [W-1:0]   canal, quociente, tc_e, ta_e, tb_e;
  logic [2:0]     bruta;
  logic           div_start, div_pronto;

  divisor_seq #(.DW(SW), .DIVISOR(N), .QW(W)) u_divisor (
    .clock     (clock),
    .reset     (reset),
    .clear     (zera),
    .start     (div_start),
    .dividendo (soma_q),
    .pronto    (div_pronto),
    .quociente (quociente)
  );

  // Each threshold moves away from the side the confirmed class sits on.
  always_comb begin
    tc_e = nv_crit;
    ta_e = nv_alto;
    tb_e = nv_baixo;
    if (classe_q != DESCONHECIDO) begin
      tc_e = W'(ajusta_limiar(32'(nv_crit), 32'(HYST), classe_q == CRITICO, T_MAX));
      ta_e = W'(ajusta_limiar(32'(nv_alto), 32'(HYST),
                              (classe_q == CRITICO) || (classe_q == ALTO), T_MAX));
      tb_e = W'(ajusta_limiar(32'(nv_baixo), 32'(HYST), classe_q != BAIXO, T_MAX));
    end
    if (quociente <= tc_e)      bruta = CRITICO;
    else if (quociente <= ta_e) bruta = ALTO;
    else if (quociente < tb_e)  bruta = NORMAL;
    else                        bruta = BAIXO;
  end

  always_comb begin
    estado_d    = estado_q;
    med_d       = med_q;
    idx_d       = idx_q;
    soma_d      = soma_q;
    min_d       = min_q;
    max_d       = max_q;
    zero_d      = zero_q;
    disc_d      = disc_q;
    media_d     = media_q;
    classe_d    = classe_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    descartar_d = descartar_q;
    div_start   = 1'b0;
    canal       = '0;
    for (int i = 0; i < N; i++)
      if (idx_q == 4'(i)) canal = med_q[i*W +: W];

    case (estado_q)
      OCIOSO: if (iniciar) estado_d = CAPTURA;
      CAPTURA: begin
        med_d    = medidas;
        soma_d   = '0;
        min_d    = '1;
        max_d    = '0;
        zero_d   = 1'b0;
        disc_d   = 1'b0;
        idx_d    = '0;
        estado_d = ACUMULA;
      end
      ACUMULA: begin
        soma_d = soma_q + SW'(canal);
        if (canal < min_q) min_d = canal;
        if (canal > max_q) max_d = canal;
        if (canal == '0)   zero_d = 1'b1;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(N-1)) estado_d = VERIFICA;
      end
      VERIFICA: begin
        if (zero_q || ((32'(max_q) - 32'(min_q)) > 32'(MAX_SPREAD))) begin
          disc_d   = 1'b1;
          estado_d = FIM;
        end else begin
          div_start = 1'b1;
          estado_d  = DIVIDE;
        end
      end
      DIVIDE: if (div_pronto) estado_d = CLASSIFICA;
      CLASSIFICA: begin
        media_d = quociente;
        if (bruta == classe_q) begin
          cnt_d = '0;
        end else if ((classe_q == DESCONHECIDO) || (bruta == CRITICO)) begin
          classe_d = bruta;
          cand_d   = bruta;
          cnt_d    = '0;
        end else if (bruta == cand_q) begin
          if ((cnt_q + 4'd1) >= 4'(CONFIRMA)) begin
            classe_d = bruta;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cand_d = bruta;
          if (CONFIRMA == 1) begin
            classe_d = bruta;
            cnt_d    = '0;
          end else begin
            cnt_d = 4'd1;
          end
        end
        estado_d = FIM;
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase

    fim_d = (estado_q == FIM);
    if (estado_q == FIM) descartar_d = disc_q;

    if (zera) begin
      estado_d    = OCIOSO;
      med_d       = '0;
      idx_d       = '0;
      soma_d      = '0;
      min_d       = '0;
      max_d       = '0;
      zero_d      = 1'b0;
      disc_d      = 1'b0;
      media_d     = '0;
      classe_d    = DESCONHECIDO;
      cand_d      = DESCONHECIDO;
      cnt_d       = '0;
      fim_d       = 1'b0;
      descartar_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      med_q       <= '0;
      idx_q       <= '0;
      soma_q      <= '0;
      min_q       <= '0;
      max_q       <= '0;
      zero_q      <= 1'b0;
      disc_q      <= 1'b0;
      media_q     <= '0;
      classe_q    <= DESCONHECIDO;
      cand_q      <= DESCONHECIDO;
      cnt_q       <= '0;
      fim_q       <= 1'b0;
      descartar_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      med_q       <= med_d;
      idx_q       <= idx_d;
      soma_q      <= soma_d;
      min_q       <= min_d;
      max_q       <= max_d;
      zero_q      <= zero_d;
      disc_q      <= disc_d;
      media_q     <= media_d;
      classe_q    <= classe_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      fim_q       <= fim_d;
      descartar_q <= descartar_d;
    end
  end

  assign media             = media_q;
  assign classificacao     = classe_q;
  assign descartar_medida  = descartar_q;
  assign fim_classificacao = fim_q;
  assign ocupado           = (estado_q != OCIOSO);
  assign db_estado         = estado_q;

endmodule

// File: tb/tb_classificador_nivel_n.sv
// Self-checking bench for classificador_nivel_n against a behavioural
// model of the round rules (mean, bands, hysteresis, confirmation).
module tb_classificador_nivel_n;

  localparam int N = 3, W = 12, MAX_SPREAD = 20, HYST = 2, CONFIRMA = 2;
  localparam int LAT_OK = 21, LAT_DESC = 6;

  logic           clock, reset, zera, iniciar;
  logic [N*W-1:0] medidas;
  logic [W-1:0]   nv_crit, nv_alto, nv_baixo;
  logic [W-1:0]   media;
  logic [2:0]     classificacao;
  logic           descartar_medida, fim_classificacao, ocupado;
  logic [3:0]     db_estado;

  classificador_nivel_n #(.N(N), .W(W), .MAX_SPREAD(MAX_SPREAD), .HYST(HYST),
                          .CONFIRMA(CONFIRMA)) dut (
    .clock(clock), .reset(reset), .zera(zera), .iniciar(iniciar),
    .medidas(medidas), .nv_crit(nv_crit), .nv_alto(nv_alto), .nv_baixo(nv_baixo),
    .media(media), .classificacao(classificacao), .descartar_medida(descartar_medida),
    .fim_classificacao(fim_classificacao), .ocupado(ocupado), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int chk = 0, err = 0;
  int m_media, m_classe, m_cand, m_cnt, m_desc;

  // distance order of classes: CRITICO closest, BAIXO farthest
  function automatic int ordem(input int cl);
    case (cl)
      4: return 0;
      3: return 1;
      2: return 2;
      1: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int efetivo(input int t, input int j);
    int v;
    if (m_classe == 0) return t;
    v = (ordem(m_classe) <= j) ? t + HYST : t - HYST;
    if (v < 0) v = 0;
    if (v > (1 << W) - 1) v = (1 << W) - 1;
    return v;
  endfunction

  task automatic model_reset();
    m_media = 0; m_classe = 0; m_cand = 0; m_cnt = 0; m_desc = 0;
  endtask

  task automatic model_round(input int a, input int b, input int c);
    int mx, mn, d, raw;
    mx = a; mn = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (b < mn) mn = b;
    if (c < mn) mn = c;
    if (a == 0 || b == 0 || c == 0 || (mx - mn) > MAX_SPREAD) begin
      m_desc = 1;
      return;
    end
    m_desc  = 0;
    d       = (a + b + c) / N;
    m_media = d;
    if (d <= efetivo(int'(nv_crit), 0))      raw = 4;
    else if (d <= efetivo(int'(nv_alto), 1)) raw = 3;
    else if (d < efetivo(int'(nv_baixo), 2)) raw = 2;
    else                                     raw = 1;
    if (raw == m_classe) m_cnt = 0;
    else if (m_classe == 0 || raw == 4) begin
      m_classe = raw; m_cand = raw; m_cnt = 0;
    end else if (raw == m_cand) begin
      m_cnt++;
      if (m_cnt >= CONFIRMA) begin m_classe = raw; m_cnt = 0; end
    end else begin
      m_cand = raw; m_cnt = 1;
      if (m_cnt >= CONFIRMA) begin m_classe = raw; m_cnt = 0; end
    end
  endtask

  task automatic run_round(input string nome, input int a, input int b, input int c);
    int lat, exp_lat;
    lat = 0;
    medidas = {W'(c), W'(b), W'(a)};
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (k == 1) medidas = 36'({$urandom, $urandom});
      if (fim_classificacao) begin lat = k; break; end
    end
    model_round(a, b, c);
    exp_lat = m_desc ? LAT_DESC : LAT_OK;
    chk++; if (lat !== exp_lat) begin err++;
      $display("FAIL %s latency: got %0d expected %0d", nome, lat, exp_lat); end
    chk++; if (media !== W'(m_media)) begin err++;
      $display("FAIL %s media: got %0d expected %0d", nome, media, m_media); end
    chk++; if (classificacao !== 3'(m_classe)) begin err++;
      $display("FAIL %s class: got %0d expected %0d", nome, classificacao, m_classe); end
    chk++; if (descartar_medida !== 1'(m_desc)) begin err++;
      $display("FAIL %s descartar: got %0b expected %0d", nome, descartar_medida, m_desc); end
    @(posedge clock); #1;
    chk++; if (fim_classificacao !== 1'b0) begin err++;
      $display("FAIL %s fim_width: got %0b expected 0", nome, fim_classificacao); end
  endtask

  task automatic test_reset();
    reset = 1'b0; zera = 1'b0; iniciar = 1'b0; medidas = '0;
    nv_crit = 12'd10; nv_alto = 12'd30; nv_baixo = 12'd100;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk++; if (media !== '0) begin err++; $display("FAIL reset media: got %0d expected 0", media); end
    chk++; if (classificacao !== 3'd0) begin err++; $display("FAIL reset class: got %0d expected 0", classificacao); end
    chk++; if (descartar_medida !== 1'b0) begin err++; $display("FAIL reset descartar: got %0b expected 0", descartar_medida); end
    chk++; if (fim_classificacao !== 1'b0) begin err++; $display("FAIL reset fim: got %0b expected 0", fim_classificacao); end
    chk++; if (ocupado !== 1'b0) begin err++; $display("FAIL reset ocupado: got %0b expected 0", ocupado); end
    chk++; if (db_estado !== 4'd0) begin err++; $display("FAIL reset estado: got %0d expected 0", db_estado); end
  endtask

  task automatic test_primeira();
    run_round("first", 50, 52, 54);
    chk++; if (media !== 12'd52 || classificacao !== 3'd2) begin err++;
      $display("FAIL first_direct: got media %0d class %0d expected 52/2", media, classificacao); end
  endtask

  task automatic test_histerese();
    run_round("hyst29", 29, 29, 29);
    chk++; if (classificacao !== 3'd2) begin err++;
      $display("FAIL hyst29_class: got %0d expected 2", classificacao); end
    run_round("hyst27a", 27, 27, 27);
    chk++; if (classificacao !== 3'd2) begin err++;
      $display("FAIL hyst27a_class: got %0d expected 2", classificacao); end
    run_round("hyst27b", 27, 27, 27);
    chk++; if (classificacao !== 3'd3) begin err++;
      $display("FAIL hyst27b_class: got %0d expected 3", classificacao); end
  endtask

  task automatic test_spread();
    run_round("spread", 40, 70, 45);
    chk++; if (descartar_medida !== 1'b1 || media !== 12'd27 || classificacao !== 3'd3) begin err++;
      $display("FAIL spread_direct: got desc %0b media %0d class %0d expected 1/27/3",
               descartar_medida, media, classificacao); end
    run_round("after_spread", 50, 50, 50);
    chk++; if (descartar_medida !== 1'b0) begin err++;
      $display("FAIL after_spread_desc: got %0b expected 0", descartar_medida); end
  endtask

  task automatic test_zero();
    run_round("zero_ch", 0, 50, 50);
    chk++; if (descartar_medida !== 1'b1 || classificacao !== 3'd3) begin err++;
      $display("FAIL zero_direct: got desc %0b class %0d expected 1/3", descartar_medida, classificacao); end
    run_round("after_zero", 50, 50, 50);
    chk++; if (classificacao !== 3'd2) begin err++;
      $display("FAIL after_zero_class: got %0d expected 2", classificacao); end
  endtask

  task automatic test_critico();
    run_round("crit5", 5, 5, 5);
    chk++; if (classificacao !== 3'd4) begin err++;
      $display("FAIL crit5_class: got %0d expected 4", classificacao); end
    run_round("crit12", 12, 12, 12);
    chk++; if (classificacao !== 3'd4) begin err++;
      $display("FAIL crit12_class: got %0d expected 4", classificacao); end
  endtask

  task automatic test_back_to_back();
    int pulsos;
    pulsos = 0;
    medidas = {12'd60, 12'd60, 12'd60};
    @(negedge clock); iniciar = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (fim_classificacao) pulsos++;
    end
    iniciar = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (fim_classificacao) pulsos++;
    end
    model_round(60, 60, 60);
    chk++; if (pulsos !== 1) begin err++;
      $display("FAIL busy_pulses: got %0d expected 1", pulsos); end
    chk++; if (media !== W'(m_media) || classificacao !== 3'(m_classe)) begin err++;
      $display("FAIL busy_result: got media %0d class %0d expected %0d/%0d",
               media, classificacao, m_media, m_classe); end
  endtask

  task automatic test_random();
    int a, b, c, base, spr;
    for (int r = 0; r < 40; r++) begin
      base = int'($urandom_range(1, 130));
      spr  = int'($urandom_range(0, 26));
      a = base + int'($urandom_range(0, spr));
      b = base + int'($urandom_range(0, spr));
      c = base + int'($urandom_range(0, spr));
      if ((r % 9) == 4) b = 0;
      run_round($sformatf("rand%0d", r), a, b, c);
    end
  endtask

  task automatic test_zera();
    bit achou;
    run_round("pre_zera", 50, 52, 54);
    medidas = {12'd80, 12'd80, 12'd80};
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    achou = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (db_estado == 4'd4) begin achou = 1'b1; break; end
    end
    chk++; if (!achou) begin err++; $display("FAIL zera_wait: got no DIVIDE state expected 4"); end
    zera = 1'b1; iniciar = 1'b1;
    @(posedge clock); #1;
    chk++; if (ocupado !== 1'b0 || classificacao !== 3'd0 || media !== '0 || db_estado !== 4'd0) begin err++;
      $display("FAIL zera_clear: got ocupado %0b class %0d media %0d estado %0d expected 0/0/0/0",
               ocupado, classificacao, media, db_estado); end
    zera = 1'b0; iniciar = 1'b0;
    model_reset();

    run_round("pre_reset", 50, 52, 54);
    medidas = {12'd80, 12'd80, 12'd80};
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1 iniciar = 1'b0;
    achou = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (db_estado == 4'd2) begin achou = 1'b1; break; end
    end
    chk++; if (!achou) begin err++; $display("FAIL reset_wait: got no ACUMULA state expected 2"); end
    #2 reset = 1'b0;
    #1;
    chk++; if (ocupado !== 1'b0 || classificacao !== 3'd0 || media !== '0 || db_estado !== 4'd0) begin err++;
      $display("FAIL async_reset: got ocupado %0b class %0d media %0d estado %0d expected 0/0/0/0",
               ocupado, classificacao, media, db_estado); end
    @(negedge clock); reset = 1'b1;
    model_reset();
    run_round("post_reset", 33, 35, 40);
  endtask

  initial begin
    test_reset();
    test_primeira();
    test_histerese();
    test_spread();
    test_zero();
    test_critico();
    test_back_to_back();
    test_random();
    test_zera();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/classificador_nivel_n.md
Name: classificador_nivel_n

Overview:
- Parametrised successor of the fixed three-sensor classifier. Captures N packed sensor distances and rejects the round on a zero channel or excessive spread.
- Computes the exact floor mean with a sequential divider, then classifies the mean against three runtime thresholds, with hysteresis and consecutive-round confirmation.
- Sits between the multi-sensor interface and the buzzer/valve/serial logic in the project datapath. The FSM (unidade de controle) drives `iniciar`.

Parameters:
- N, 3: number of sensor channels, 2..8.
- W, 12: width of each distance and threshold, in BCD-agnostic binary.
- MAX_SPREAD, 20: maximum allowed max-min among channels before the round is discarded.
- HYST, 2: hysteresis margin applied to the thresholds.
- CONFIRMA, 2: number of consecutive agreeing valid rounds required to change class, 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- zera  in  1  synchronous clear; same effect as reset, and wins over every other input.
- iniciar  in  1  start request; sampled only in OCIOSO.
- medidas  in  N*W  packed channel distances; channel i is bits [i*W+W-1 : i*W].
- nv_crit  in  W  critical threshold (lowest distance).
- nv_alto  in  W  high-water threshold.
- nv_baixo  in  W  low-water threshold.
- media  out  W  last accepted mean.
- classificacao  out  3  confirmed class.
- descartar_medida  out  1  valid with the fim pulse; 1 means the round was rejected.
- fim_classificacao  out  1  one-cycle completion pulse.
- ocupado  out  1  high in every state except OCIOSO.
- db_estado  out  4  current state code.

Behaviour:
- Reset and zera values:
  - media=0, classificacao=DESCONHECIDO(0), descartar_medida=0, fim_classificacao=0, ocupado=0.
  - Confirmation counter = 0, candidate = DESCONHECIDO, state = OCIOSO.
- Class codes: DESCONHECIDO=0, BAIXO=1, NORMAL=2, ALTO=3, CRITICO=4.
- States and transitions:
  - OCIOSO: on iniciar=1, go to CAPTURA.
  - CAPTURA (1 cycle): register medidas; clear sum, min, max, and the zero flag.
  - ACUMULA (N cycles): one channel per cycle. Sum is W+clog2(N) bits and never overflows. Update min and max; set the zero flag if any channel equals 0.
  - VERIFICA (1 cycle): if the zero flag is set, or max-min > MAX_SPREAD, go to FIM with discard=1. Otherwise go to DIVIDE.
  - DIVIDE (SW = W+clog2(N) cycles): restoring division sum/N, floor. The quotient always fits in W bits.
  - CLASSIFICA (1 cycle): raw classification, hysteresis and confirmation update (rules below).
  - FIM (1 cycle): fim_classificacao=1, then return to OCIOSO.
- Latency: fim_classificacao is asserted exactly N+SW+4 cycles after the edge that samples iniciar. A discarded round takes N+3 cycles.
- Discarded rounds leave media, classificacao, the candidate and the confirmation counter unchanged.
- descartar_medida is held until the next round's FIM.
- Raw bands on distance d:
  - d ≤ tc → CRITICO
  - else d ≤ ta → ALTO
  - else d < tb → NORMAL
  - else BAIXO
- Hysteresis:
  - Each effective threshold (tc, ta, tb) equals its input threshold ±HYST, moved away from the current confirmed class. Use t+HYST when the current class lies on the low-distance side of t, and t−HYST otherwise.
  - Results saturate at 0 and 2^W−1.
  - With DESCONHECIDO, the raw thresholds are used.
- Confirmation and update rules:
  - If raw = current class: counter cleared.
  - If current = DESCONHECIDO, or raw = CRITICO: adopt immediately. CRITICO adoption is a safety bypass.
  - Else if raw = candidate: counter+1. At CONFIRMA, adopt and clear the counter.
  - Else: candidate = raw, counter = 1. If CONFIRMA=1, adopt immediately.
  - media is updated on every non-discarded round, independent of confirmation.
- Boundary conditions:
  - iniciar while ocupado is ignored and not queued.
  - Changes to medidas after CAPTURA do not affect the round.
  - Thresholds are sampled in CLASSIFICA.
  - Inconsistent thresholds (tc ≥ ta, etc.) resolve by band priority order with no special handling.

Decomposition:
- Package classificador_pkg holds:
  - class code constants;
  - state encoding constants (OCIOSO=0 … FIM=6);
  - a clog2 function;
  - a saturating add/sub helper for thresholds.
- One sub-module, divisor_seq: restoring divider with parameters dividend width and divisor constant N. Handshake: start in, pronto pulse, quotient out, fixed SW-cycle latency.

Test Plan:
All scenarios use N=3, W=12, HYST=2, CONFIRMA=2, MAX_SPREAD=20, nv_crit=10, nv_alto=30, nv_baixo=100, so SW=14 and latency is 21 cycles.
1. Release reset; medidas=50,52,54; pulse iniciar → fim pulse exactly 21 cycles later, media=52, classificacao=NORMAL (adopted immediately from DESCONHECIDO), descartar=0.
2. From NORMAL, medidas=29,29,29 → media=29, class stays NORMAL (effective ta=28). Then 27,27,27 twice → NORMAL after the first round, ALTO after the second.
3. medidas=40,70,45 → spread 30 > 20; fim after 6 cycles with descartar=1; media and class unchanged. A following valid round clears descartar.
4. medidas=0,50,50 → discarded; class and counter unchanged.
5. From NORMAL, medidas=5,5,5 → CRITICO in a single round (bypass). Then 12,12,12 → stays CRITICO (effective tc=12).
6. Assert zera during DIVIDE → next cycle ocupado=0, classificacao=DESCONHECIDO, media=0. A reset pulse mid-ACUMULA gives the same result asynchronously. iniciar held during a busy round → exactly one fim pulse.
